// File: rtl/dm_axi_pkg.sv
// Shared types and constants for the data-memory AXI master.
package dm_axi_pkg;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WRITE,
    S_WRESP,
    S_DONE
  } state_e;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3 encodings
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // AXI field constants
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/dm_axi_master_if.sv
// AXI4 channel bundle between the data-memory master and its slave.
interface dm_axi_master_if #(
  parameter int ID_W = 4
);

  // Read address channel
  logic [ID_W-1:0] ARID;
  logic [31:0]     ARADDR;
  logic [3:0]      ARLEN;
  logic [2:0]      ARSIZE;
  logic [1:0]      ARBURST;
  logic            ARVALID;
  logic            ARREADY;

  // Read data channel
  logic [ID_W-1:0] RID;
  logic [31:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;
  logic            RVALID;
  logic            RREADY;

  // Write address channel
  logic [ID_W-1:0] AWID;
  logic [31:0]     AWADDR;
  logic [3:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWVALID;
  logic            AWREADY;

  // Write data channel
  logic [31:0]     WDATA;
  logic [3:0]      WSTRB;
  logic            WLAST;
  logic            WVALID;
  logic            WREADY;

  // Write response channel
  logic [ID_W-1:0] BID;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );

endinterface

// File: rtl/dm_axi_master_store_align.sv
// Store lane placement: byte strobes and replicated data for SB/SH/SW.
module store_align
  import dm_axi_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  strb,
  output logic [31:0] data
);

  // Replicate the source across lanes and enable only the addressed ones
  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    strb = 4'b1111;
    data = wdata;
    case (funct3)
      F3_SB: begin
        strb = 4'b0001 << addr_lo;
        data = {4{wdata[7:0]}};
      end
      F3_SH: begin
        strb = addr_lo[1] ? 4'b1100 : 4'b0011;
        data = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_axi_master.sv
// MEM-stage data-memory master: one single-beat AXI4 read or write per
// pipeline load/store, stalling the pipeline until the response returns.
module dm_axi_master
  import dm_axi_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int MASTER_ID = 1
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic [31:0] o_DM_DI,
  output logic        o_resp_err,
  dm_axi_master_if.master axi
);

  state_e      state_q, state_d;
  logic [29:0] word_addr_q;
  logic [3:0]  strb_q;
  logic [31:0] wdata_q;
  logic [1:0]  resp_q;
  logic [31:0] dm_di_q;
  logic        arvalid_q, awvalid_q, wvalid_q;
  logic        aw_done_q, w_done_q;

  logic [3:0]  strb_al;
  logic [31:0] wdata_al;
  logic        accept, ar_hs, aw_hs, w_hs;

  store_align u_store_align (
    .funct3  (i_funct3),
    .addr_lo (i_addr[1:0]),
    .wdata   (i_wdata),
    .strb    (strb_al),
    .data    (wdata_al)
  );

  assign accept = (state_q == S_IDLE) && i_req;
  assign ar_hs  = arvalid_q && axi.ARREADY;
  assign aw_hs  = awvalid_q && axi.AWREADY;
  assign w_hs   = wvalid_q && axi.WREADY;

  // Fixed single-beat word-sized INCR fields
  assign axi.ARID    = ID_W'(MASTER_ID);
  assign axi.ARADDR  = {word_addr_q, 2'b00};
  assign axi.ARLEN   = 4'd0;
  assign axi.ARSIZE  = SIZE_WORD;
  assign axi.ARBURST = BURST_INCR;
  assign axi.ARVALID = arvalid_q;

  assign axi.AWID    = ID_W'(MASTER_ID);
  assign axi.AWADDR  = {word_addr_q, 2'b00};
  assign axi.AWLEN   = 4'd0;
  assign axi.AWSIZE  = SIZE_WORD;
  assign axi.AWBURST = BURST_INCR;
  assign axi.AWVALID = awvalid_q;

  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = strb_q;
  assign axi.WLAST   = 1'b1;
  assign axi.WVALID  = wvalid_q;

  assign o_DM_DI = dm_di_q;

  // Response IDs and RLAST carry no information for single-beat transfers
  logic unused_ok;
  assign unused_ok = &{1'b0, axi.RID, axi.BID, axi.RLAST};

  // State register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (!ARESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_d    = state_q;
    axi.RREADY = 1'b0;
    axi.BREADY = 1'b0;
    o_stall    = i_req && (state_q != S_DONE);
    o_resp_err = 1'b0;
    case (state_q)
      S_IDLE:  if (i_req) state_d = i_we ? S_WRITE : S_RADDR;
      S_RADDR: if (ar_hs) state_d = S_RDATA;
      S_RDATA: begin
        axi.RREADY = 1'b1;
        if (axi.RVALID) state_d = S_DONE;
      end
      S_WRITE: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_WRESP;
      S_WRESP: begin
        axi.BREADY = 1'b1;
        if (axi.BVALID) state_d = S_DONE;
      end
      S_DONE: begin
        o_resp_err = (resp_q != RESP_OKAY);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered valids: raised on accept, each dropped by its own handshake
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (accept) begin
      arvalid_q <= !i_we;
      awvalid_q <= i_we;
      wvalid_q  <= i_we;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (ar_hs) arvalid_q <= 1'b0;
      if (aw_hs) begin
        awvalid_q <= 1'b0;
        aw_done_q <= 1'b1;
      end
      if (w_hs) begin
        wvalid_q <= 1'b0;
        w_done_q <= 1'b1;
      end
    end
  end

  // Request payload latch and response capture
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      word_addr_q <= '0;
      strb_q      <= '0;
      wdata_q     <= '0;
      resp_q      <= RESP_OKAY;
      dm_di_q     <= '0;
    end else begin
      if (accept) begin
        word_addr_q <= i_addr[31:2];
        strb_q      <= strb_al;
        wdata_q     <= wdata_al;
      end
      if (state_q == S_RDATA && axi.RVALID) begin
        dm_di_q <= axi.RDATA;
        resp_q  <= axi.RRESP;
      end
      if (state_q == S_WRESP && axi.BVALID) resp_q <= axi.BRESP;
    end
  end

endmodule

// File: tb/tb_dm_axi_master.sv
// Directed bench for dm_axi_master with a delay-programmable AXI slave.
module tb_dm_axi_master;
  import dm_axi_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        i_req, i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata;
  logic        o_stall, o_resp_err;
  logic [31:0] o_DM_DI;

  int n_checks = 0;
  int n_errors = 0;

  // Per-transaction observations
  logic [31:0] obs_addr, obs_wdata, obs_di;
  logic [3:0]  obs_strb;
  logic [12:0] obs_ar_fixed, obs_aw_fixed;
  logic        obs_wlast, obs_err_done;
  int          obs_stall, obs_err_cnt, obs_proto, obs_b_hs, obs_ar_cyc;
  int          obs_aw_idx, obs_w_idx;

  localparam logic [12:0] FIXED_EXP = {4'd1, 4'd0, 3'b010, 2'b01};

  dm_axi_master_if #(.ID_W(4)) axi ();

  dm_axi_master #(.ID_W(4), .MASTER_ID(1)) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .i_req      (i_req),
    .i_we       (i_we),
    .i_funct3   (i_funct3),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_stall    (o_stall),
    .o_DM_DI    (o_DM_DI),
    .o_resp_err (o_resp_err),
    .axi        (axi)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic slave_idle();
    axi.ARREADY = 1'b0;
    axi.RVALID  = 1'b0;
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
  endtask

  // One request from the IDLE cycle through DONE; called at a falling edge.
  task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [1:0] resp,
                         input int ar_dly, input int r_dly, input int aw_dly,
                         input int w_dly, input int b_dly);
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, cyc;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend;
    bit ar_seen, aw_seen, w_seen, ar_wait, aw_wait, w_wait, done;
    logic [31:0] ar_hold, aw_hold, wd_hold;
    logic [3:0]  ws_hold;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; cyc = 0;
    ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; r_pend = 0; b_pend = 0;
    ar_seen = 0; aw_seen = 0; w_seen = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
    done = 0; ar_hold = '0; aw_hold = '0; wd_hold = '0; ws_hold = '0;
    obs_addr = '0; obs_wdata = '0; obs_di = '0; obs_strb = '0;
    obs_ar_fixed = '0; obs_aw_fixed = '0; obs_wlast = 0; obs_err_done = 0;
    obs_stall = 0; obs_err_cnt = 0; obs_proto = 0; obs_b_hs = 0; obs_ar_cyc = 0;
    obs_aw_idx = -1; obs_w_idx = -1;
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    while (!done && cyc < 64) begin
      // Retire handshakes completed at the last rising edge
      if (ar_hs) begin ar_seen = 1; r_pend = 1; end
      if (r_hs) r_pend = 0;
      if (aw_hs) aw_seen = 1;
      if (w_hs) w_seen = 1;
      if ((aw_hs || w_hs) && aw_seen && w_seen) b_pend = 1;
      if (b_hs) b_pend = 0;
      // A valid holds with stable payload until its handshake and never reissues
      if (ar_wait && (!axi.ARVALID || axi.ARADDR !== ar_hold)) obs_proto++;
      if (aw_wait && (!axi.AWVALID || axi.AWADDR !== aw_hold)) obs_proto++;
      if (w_wait && (!axi.WVALID || axi.WDATA !== wd_hold || axi.WSTRB !== ws_hold)) obs_proto++;
      if ((ar_seen && axi.ARVALID) || (aw_seen && axi.AWVALID) || (w_seen && axi.WVALID))
        obs_proto++;
      // AR
      axi.ARREADY = axi.ARVALID && (ar_cnt >= ar_dly);
      if (axi.ARVALID) begin ar_cnt++; obs_ar_cyc++; end
      ar_hs = axi.ARVALID && axi.ARREADY;
      ar_wait = axi.ARVALID && !ar_hs;
      ar_hold = axi.ARADDR;
      if (ar_hs) begin
        obs_addr = axi.ARADDR;
        obs_ar_fixed = {axi.ARID, axi.ARLEN, axi.ARSIZE, axi.ARBURST};
      end
      // R
      if (r_pend && r_cnt >= r_dly) begin
        axi.RVALID = 1'b1; axi.RDATA = rdata; axi.RRESP = resp;
      end else begin
        axi.RVALID = 1'b0;
        if (r_pend) r_cnt++;
      end
      r_hs = axi.RVALID && axi.RREADY;
      // AW
      axi.AWREADY = axi.AWVALID && (aw_cnt >= aw_dly);
      if (axi.AWVALID) aw_cnt++;
      aw_hs = axi.AWVALID && axi.AWREADY;
      aw_wait = axi.AWVALID && !aw_hs;
      aw_hold = axi.AWADDR;
      if (aw_hs) begin
        obs_addr = axi.AWADDR;
        obs_aw_fixed = {axi.AWID, axi.AWLEN, axi.AWSIZE, axi.AWBURST};
        obs_aw_idx = cyc;
      end
      // W
      axi.WREADY = axi.WVALID && (w_cnt >= w_dly);
      if (axi.WVALID) w_cnt++;
      w_hs = axi.WVALID && axi.WREADY;
      w_wait = axi.WVALID && !w_hs;
      wd_hold = axi.WDATA;
      ws_hold = axi.WSTRB;
      if (w_hs) begin
        obs_strb = axi.WSTRB; obs_wdata = axi.WDATA; obs_wlast = axi.WLAST;
        obs_w_idx = cyc;
      end
      // B
      if (b_pend && b_cnt >= b_dly) begin
        axi.BVALID = 1'b1; axi.BRESP = resp;
      end else begin
        axi.BVALID = 1'b0;
        if (b_pend) b_cnt++;
      end
      b_hs = axi.BVALID && axi.BREADY;
      if (b_hs) obs_b_hs++;
      #1;
      if (o_stall) obs_stall++;
      else begin
        done = 1;
        obs_di = o_DM_DI;
        obs_err_done = o_resp_err;
      end
      if (o_resp_err) obs_err_cnt++;
      @(negedge ACLK);
      cyc++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    i_req = 1'b0;
    slave_idle();
    #1;
    if (o_resp_err) obs_err_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ARESETn = 1'b0;
    i_req = 1'b0; i_we = 1'b0; i_funct3 = '0; i_addr = '0; i_wdata = '0;
    slave_idle();
    axi.RDATA = '0; axi.RRESP = '0; axi.RID = '0; axi.RLAST = 1'b1;
    axi.BRESP = '0; axi.BID = '0;
    #1;
    check("rst_arvalid", axi.ARVALID, 0);
    check("rst_awvalid", axi.AWVALID, 0);
    check("rst_wvalid", axi.WVALID, 0);
    check("rst_rready", axi.RREADY, 0);
    check("rst_bready", axi.BREADY, 0);
    check("rst_resp_err", o_resp_err, 0);
    check("rst_dm_di", o_DM_DI, 0);
    check("rst_stall", o_stall, 0);
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);

    // LW, zero wait states
    run_txn("lw", 0, F3_LW, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0);
    check("lw_araddr", obs_addr, 32'h0000_1004);
    check("lw_di", obs_di, 32'hDEAD_BEEF);
    check("lw_stall", obs_stall, 3);
    check("lw_fixed", 32'(obs_ar_fixed), 32'(FIXED_EXP));
    check("lw_err", obs_err_cnt, 0);
    check("lw_proto", obs_proto, 0);

    // SB to the top byte lane; read word must be held across a store
    run_txn("sb", 1, F3_SB, 32'h0000_2003, 32'h0000_00A5, 32'h0, 2'b00, 0, 0, 0, 0, 0);
    check("sb_awaddr", obs_addr, 32'h0000_2000);
    check("sb_wstrb", 32'(obs_strb), 32'h8);
    check("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
    check("sb_stall", obs_stall, 3);
    check("sb_fixed", 32'(obs_aw_fixed), 32'(FIXED_EXP));
    check("sb_wlast", 32'(obs_wlast), 1);
    check("sb_di_held", obs_di, 32'hDEAD_BEEF);

    // SH upper half, AWREADY three cycles behind WREADY
    run_txn("sh_hi", 1, F3_SH, 32'h0000_2002, 32'h0000_1234, 32'h0, 2'b00, 0, 0, 3, 0, 0);
    check("sh_hi_wstrb", 32'(obs_strb), 32'hC);
    check("sh_hi_wdata", obs_wdata, 32'h1234_1234);
    check("sh_hi_aw_lag", obs_aw_idx - obs_w_idx, 3);
    check("sh_hi_proto", obs_proto, 0);
    check("sh_hi_b_hs", obs_b_hs, 1);
    check("sh_hi_stall", obs_stall, 6);

    // SH lower half, WREADY two cycles behind AWREADY
    run_txn("sh_lo", 1, F3_SH, 32'h0000_2001, 32'h0000_BEEF, 32'h0, 2'b00, 0, 0, 0, 2, 0);
    check("sh_lo_awaddr", obs_addr, 32'h0000_2000);
    check("sh_lo_wstrb", 32'(obs_strb), 32'h3);
    check("sh_lo_wdata", obs_wdata, 32'hBEEF_BEEF);
    check("sh_lo_stall", obs_stall, 5);
    check("sh_lo_proto", obs_proto, 0);

    // SB to lane 1 with a slow B response
    run_txn("sb1", 1, F3_SB, 32'h0000_2101, 32'h1234_5677, 32'h0, 2'b00, 0, 0, 0, 0, 2);
    check("sb1_wstrb", 32'(obs_strb), 32'h2);
    check("sb1_wdata", obs_wdata, 32'h7777_7777);
    check("sb1_stall", obs_stall, 5);

    // LB with ARREADY held low for five cycles
    run_txn("lb", 0, F3_LB, 32'h0000_3001, 32'h0, 32'h0102_0304, 2'b00, 5, 0, 0, 0, 0);
    check("lb_araddr", obs_addr, 32'h0000_3000);
    check("lb_arvalid_cyc", obs_ar_cyc, 6);
    check("lb_proto", obs_proto, 0);
    check("lb_stall", obs_stall, 8);
    check("lb_di", obs_di, 32'h0102_0304);

    // SW with SLVERR on B
    run_txn("sw_err", 1, F3_SW, 32'h0000_4000, 32'hCAFE_F00D, 32'h0, 2'b10, 0, 0, 0, 0, 0);
    check("sw_err_wstrb", 32'(obs_strb), 32'hF);
    check("sw_err_wdata", obs_wdata, 32'hCAFE_F00D);
    check("sw_err_in_done", 32'(obs_err_done), 1);
    check("sw_err_pulses", obs_err_cnt, 1);
    check("sw_err_idle", 32'(dut.state_q), 32'(S_IDLE));

    // LHU with a slow, erroring R response
    run_txn("lhu_err", 0, F3_LHU, 32'h0000_5006, 32'h0, 32'h8765_4321, 2'b11, 0, 2, 0, 0, 0);
    check("lhu_err_araddr", obs_addr, 32'h0000_5004);
    check("lhu_err_di", obs_di, 32'h8765_4321);
    check("lhu_err_stall", obs_stall, 5);
    check("lhu_err_pulses", obs_err_cnt, 1);

    // Reset asserted while waiting in RDATA
    i_req = 1'b1; i_we = 1'b0; i_funct3 = F3_LW; i_addr = 32'h0000_1004;
    @(negedge ACLK);
    axi.ARREADY = 1'b1;
    check("rst_mid_arvalid_pre", axi.ARVALID, 1);
    @(negedge ACLK);
    axi.ARREADY = 1'b0;
    check("rst_mid_rready_pre", axi.RREADY, 1);
    #2 ARESETn = 1'b0;
    #1;
    check("rst_mid_arvalid", axi.ARVALID, 0);
    check("rst_mid_rready", axi.RREADY, 0);
    check("rst_mid_awvalid", axi.AWVALID, 0);
    check("rst_mid_wvalid", axi.WVALID, 0);
    check("rst_mid_bready", axi.BREADY, 0);
    check("rst_mid_state", 32'(dut.state_q), 32'(S_IDLE));
    check("rst_mid_dm_di", o_DM_DI, 0);
    i_req = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    run_txn("lw_post", 0, F3_LW, 32'h0000_1008, 32'h0, 32'h1357_9BDF, 2'b00, 0, 0, 0, 0, 0);
    check("lw_post_araddr", obs_addr, 32'h0000_1008);
    check("lw_post_di", obs_di, 32'h1357_9BDF);
    check("lw_post_stall", obs_stall, 3);
    check("lw_post_proto", obs_proto, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dm_axi_master.md
# dm_axi_master

Data-memory access unit for the RV32I core. It sits in the MEM stage, directly upstream of the load-alignment logic. It converts a pipeline load/store request into single-beat AXI4 read or write transactions and generates store byte-strobes and replicated store data. It stalls the pipeline until the transaction completes, then presents the raw 32-bit read word for sign/zero extension downstream.

## Interface
Parameters:
- ID_W, 4: AXI ID width.
- MASTER_ID, 1: constant driven on ARID/AWID.

Ports:
- ACLK  in  1  core clock; all logic is rising-edge.
- ARESETn  in  1  asynchronous, active-low reset.
- i_req  in  1  MEM stage holds a valid load/store; stays high and stable until o_stall falls.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- i_addr  in  32  effective address (ALU result).
- i_wdata  in  32  store source (rs2).
- o_stall  out  1  freeze the pipeline.
- o_DM_DI  out  32  raw read word, register-held, for load alignment.
- o_resp_err  out  1  one-cycle pulse in DONE if RRESP/BRESP != OKAY.
- AR channel: ARID out ID_W; ARADDR out 32; ARLEN out 4; ARSIZE out 3; ARBURST out 2; ARVALID out 1; ARREADY in 1.
- R channel: RID in ID_W; RDATA in 32; RRESP in 2; RLAST in 1; RVALID in 1; RREADY out 1.
- AW channel: AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, AWREADY, with the same widths as AR.
- W channel: WDATA out 32; WSTRB out 4; WLAST out 1; WVALID out 1; WREADY in 1.
- B channel: BID in ID_W; BRESP in 2; BVALID in 1; BREADY out 1.

## Operation
- FSM states: IDLE, RADDR, RDATA, WRITE, WRESP, DONE.
- IDLE:
  - When i_req is high, latch the word-aligned address {i_addr[31:2],2'b00}, the strobe and the aligned write data.
  - Go to RADDR if i_we=0, or to WRITE if i_we=1.
- RADDR: ARVALID=1. On ARREADY, go to RDATA.
- RDATA: RREADY=1. On RVALID, capture RDATA into o_DM_DI and RRESP, then go to DONE.
- WRITE:
  - AWVALID and WVALID rise together.
  - Each valid drops independently on its own handshake. Sticky flags aw_done and w_done track the two handshakes.
  - When both flags are set (including the same-cycle case), go to WRESP.
- WRESP: BREADY=1. On BVALID, capture BRESP and go to DONE.
- DONE: o_stall=0 for exactly one cycle so the pipeline advances. Then go to IDLE.
- o_stall = i_req && (state != DONE). It is combinational, so it is high in the request cycle itself.
- Fixed AXI fields: ARLEN/AWLEN=0, ARSIZE/AWSIZE=3'b010, ARBURST/AWBURST=2'b01 (INCR), WLAST=1, IDs=MASTER_ID.
- Store alignment, with a = i_addr[1:0]:
  - SB: WSTRB=4'b0001<<a; WDATA={4{wdata[7:0]}}.
  - SH: WSTRB = a[1] ? 4'b1100 : 4'b0011; WDATA={2{wdata[15:0]}}.
  - SW: WSTRB=4'b1111; WDATA=wdata.
- Misaligned accesses raise no trap. They are handled by the rules above.
- RID/BID and RLAST are ignored.

## Timing
- Reset values: state=IDLE. ARVALID, AWVALID, WVALID, RREADY, BREADY and o_resp_err are all 0. o_DM_DI=0.
- Reset asserted mid-transaction:
  - All valids drop immediately (asynchronous) and the FSM returns to IDLE.
  - No outstanding transaction is tracked.
- All AXI valids are registered. Once asserted, a valid and its payload stay stable until its ready is seen.
- Best-case load, request seen in cycle T:
  - ARVALID in T+1.
  - RREADY in T+2.
  - DONE in T+3, where o_stall=0 and o_DM_DI is valid.
  - o_DM_DI holds until the next read completes.
- Best-case store: AWVALID/WVALID in T+1, WRESP in T+2, DONE in T+3.
- Each wait cycle on ARREADY, RVALID, AWREADY, WREADY or BVALID adds one cycle.
- A new request is accepted no earlier than the IDLE cycle after DONE, so back-to-back accesses cost at least 4 cycles each.

## Structure
- Package dm_axi_pkg holds:
  - the state enum;
  - funct3 localparams for SB/SH/SW and the loads;
  - AXI constants SIZE_WORD, BURST_INCR and RESP_OKAY.
- Sub-module store_align is purely combinational and maps (funct3, addr[1:0], wdata) to (WSTRB, WDATA). It is instantiated once; its outputs are latched in IDLE.

## Test plan
- LW at 0x1004, ARREADY and RVALID immediate, RDATA=0xDEADBEEF -> ARADDR=0x1004, o_DM_DI=0xDEADBEEF, o_stall high for exactly 3 cycles.
- SB at 0x2003 with wdata=0x000000A5 -> AWADDR=0x2000, WSTRB=4'b1000, WDATA=0xA5A5A5A5.
- SH at 0x2002 with wdata=0x1234 and AWREADY delayed 3 cycles after WREADY -> WVALID drops after its own handshake, AWVALID holds until its ready, then one B handshake and one DONE cycle.
- LB at 0x3001 with ARREADY held low for 5 cycles -> ARVALID and ARADDR stable throughout, o_stall stays high until DONE.
- SW where BRESP=2'b10 -> o_resp_err pulses for 1 cycle in DONE, and the FSM returns to IDLE.
- ARESETn pulled low while in RDATA -> all valids and readies are 0 immediately, state=IDLE. After release, a new LW completes normally.
